// File: rtl/tcm_loader_pkg.sv
// tcm_loader_pkg: shared types, default sizes and address-width helpers for the
// TCM boot loader. Optional feature macro: TCM_LOADER_CHKSUM_EN (see tcm_loader).
package tcm_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int ITCM_SIZE_DEF = 16384;

  // Byte counter / length width; one bit wider than load_len so the
  // clamped length and the counter can both reach ITCM_SIZE.
  localparam int CNT_W = 16;

  // ITCM word index width (64-bit words).
  function automatic int itcm_aw(input int size);
    return $clog2(size / 8);
  endfunction

  // DTCM word index width (32-bit words).
  function automatic int dtcm_aw(input int size);
    return $clog2(size / 4);
  endfunction

  // Byte-lane enables for a 32-bit word whose highest filled lane is 'lane'.
  function automatic logic [3:0] lane_en(input logic [1:0] lane);
    logic [3:0] en;
    case (lane)
      2'd0:    en = 4'b0001;
      2'd1:    en = 4'b0011;
      2'd2:    en = 4'b0111;
      2'd3:    en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/tcm_word_pack.sv
// tcm_word_pack: assembles the little-endian byte stream into 64-bit ITCM and
// 32-bit DTCM words and issues one-cycle registered writes when a word fills
// or the stream ends. Unfilled lanes of a flushed word are always zero.
module tcm_word_pack
  import tcm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        clr,
  input  logic        acc,
  input  logic        last,
  input  logic [2:0]  lane,
  input  logic [7:0]  byte_data,
  output logic        itcm_we,
  output logic [63:0] itcm_wdata,
  output logic [3:0]  dtcm_we,
  output logic [31:0] dtcm_wdata
);

  logic [63:0] ibuf_r;
  logic [31:0] dbuf_r;
  logic [63:0] inext_s;
  logic [31:0] dnext_s;
  logic        iflush_s;
  logic        dflush_s;
  logic        itcm_we_r;
  logic [63:0] itcm_wdata_r;
  logic [3:0]  dtcm_we_r;
  logic [31:0] dtcm_wdata_r;

  // Merge the incoming byte into the partial words and decide on flushes.
  always_comb begin
    inext_s  = ibuf_r;
    dnext_s  = dbuf_r;
    iflush_s = 1'b0;
    dflush_s = 1'b0;
    if (acc) begin
      inext_s[{lane, 3'b000} +: 8]      = byte_data;
      dnext_s[{lane[1:0], 3'b000} +: 8] = byte_data;
      iflush_s = (lane == 3'd7) || last;
      dflush_s = (lane[1:0] == 2'd3) || last;
    end else begin
      iflush_s = 1'b0;
      dflush_s = 1'b0;
    end
  end

  // ITCM partial word and registered 64-bit write strobe/data.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      ibuf_r       <= 64'h0;
      itcm_we_r    <= 1'b0;
      itcm_wdata_r <= 64'h0;
    end else if (clr) begin
      ibuf_r       <= 64'h0;
      itcm_we_r    <= 1'b0;
    end else begin
      itcm_we_r <= iflush_s;
      if (iflush_s) begin
        itcm_wdata_r <= inext_s;
        ibuf_r       <= 64'h0;
      end else begin
        ibuf_r <= inext_s;
      end
    end
  end

  // DTCM partial word and registered lane-enabled 32-bit write.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      dbuf_r       <= 32'h0;
      dtcm_we_r    <= 4'h0;
      dtcm_wdata_r <= 32'h0;
    end else if (clr) begin
      dbuf_r       <= 32'h0;
      dtcm_we_r    <= 4'h0;
    end else begin
      if (dflush_s) begin
        dtcm_we_r    <= lane_en(lane[1:0]);
        dtcm_wdata_r <= dnext_s;
        dbuf_r       <= 32'h0;
      end else begin
        dtcm_we_r <= 4'h0;
        dbuf_r    <= dnext_s;
      end
    end
  end

  assign itcm_we    = itcm_we_r;
  assign itcm_wdata = itcm_wdata_r;
  assign dtcm_we    = dtcm_we_r;
  assign dtcm_wdata = dtcm_wdata_r;

endmodule

// File: rtl/tcm_loader.sv
// tcm_loader: streams a boot image byte-by-byte into ITCM (64-bit) and DTCM
// (32-bit) while holding the core in reset, then releases it.
// Optional: define TCM_LOADER_CHKSUM_EN to get a running byte-sum on chksum;
// otherwise chksum is tied to zero and no accumulator is built.
module tcm_loader
  import tcm_loader_pkg::*;
#(
  parameter int ITCM_SIZE = ITCM_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           cpurst_n,
  input  logic                           start,
  input  logic [14:0]                    load_len,
  input  logic                           byte_valid,
  input  logic [7:0]                     byte_data,
  output logic                           byte_ready,
  output logic                           itcm_we,
  output logic [itcm_aw(ITCM_SIZE)-1:0]  itcm_addr,
  output logic [63:0]                    itcm_wdata,
  output logic [3:0]                     dtcm_we,
  output logic [dtcm_aw(ITCM_SIZE)-1:0]  dtcm_addr,
  output logic [31:0]                    dtcm_wdata,
  output logic                           core_rst,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    chksum
);

  localparam int          IAW    = itcm_aw(ITCM_SIZE);
  localparam int          DAW    = dtcm_aw(ITCM_SIZE);
  localparam logic [31:0] SIZE_W = 32'(ITCM_SIZE);

  state_e             state_r;
  state_e             state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   len_r;
  logic [CNT_W-1:0]   eff_len_s;
  logic               start_ok_s;
  logic               acc_s;
  logic               last_s;
  logic               byte_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               core_rst_r;
  logic               byte_ready_nx_s;
  logic               busy_nx_s;
  logic               done_nx_s;
  logic               core_rst_nx_s;
  logic [IAW-1:0]     itcm_addr_r;
  logic [DAW-1:0]     dtcm_addr_r;

  // Length is clamped to the TCM size; start only counts in IDLE or RUN.
  assign eff_len_s  = ({17'd0, load_len} > SIZE_W) ? SIZE_W[CNT_W-1:0] : {1'b0, load_len};
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_RUN));
  assign acc_s      = byte_valid && byte_ready_r;
  assign last_s     = ((cnt_r + 16'd1) == len_r);

  // State register.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_nx_s = (eff_len_s == 16'd0) ? ST_DRAIN : ST_LOAD;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_LOAD: begin
        if (acc_s && last_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_DRAIN: state_nx_s = ST_RUN;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the status outputs can be registered.
  always_comb begin
    byte_ready_nx_s = 1'b0;
    busy_nx_s       = 1'b0;
    done_nx_s       = 1'b0;
    core_rst_nx_s   = 1'b1;
    case (state_nx_s)
      ST_IDLE:  core_rst_nx_s = 1'b1;
      ST_LOAD: begin
        byte_ready_nx_s = 1'b1;
        busy_nx_s       = 1'b1;
      end
      ST_DRAIN: busy_nx_s = 1'b1;
      ST_RUN: begin
        done_nx_s     = 1'b1;
        core_rst_nx_s = 1'b0;
      end
      default:  core_rst_nx_s = 1'b1;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      core_rst_r   <= 1'b1;
    end else begin
      byte_ready_r <= byte_ready_nx_s;
      busy_r       <= busy_nx_s;
      done_r       <= done_nx_s;
      core_rst_r   <= core_rst_nx_s;
    end
  end

  // Byte counter and latched effective length.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      cnt_r <= 16'd0;
      len_r <= 16'd0;
    end else if (start_ok_s) begin
      cnt_r <= 16'd0;
      len_r <= eff_len_s;
    end else if (acc_s) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Word addresses track the byte being accepted; they line up with the
  // write strobes that the packer issues one cycle later.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      itcm_addr_r <= '0;
      dtcm_addr_r <= '0;
    end else if (acc_s) begin
      itcm_addr_r <= cnt_r[IAW+2:3];
      dtcm_addr_r <= cnt_r[DAW+1:2];
    end else begin
      itcm_addr_r <= itcm_addr_r;
      dtcm_addr_r <= dtcm_addr_r;
    end
  end

  tcm_word_pack u_pack (
    .clk        (clk),
    .cpurst_n   (cpurst_n),
    .clr        (start_ok_s),
    .acc        (acc_s),
    .last       (last_s),
    .lane       (cnt_r[2:0]),
    .byte_data  (byte_data),
    .itcm_we    (itcm_we),
    .itcm_wdata (itcm_wdata),
    .dtcm_we    (dtcm_we),
    .dtcm_wdata (dtcm_wdata)
  );

`ifdef TCM_LOADER_CHKSUM_EN
  logic [31:0] chksum_r;

  // Modulo-2^32 byte-sum of the accepted image, restarted by each load.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      chksum_r <= 32'h0;
    end else if (start_ok_s) begin
      chksum_r <= 32'h0;
    end else if (acc_s) begin
      chksum_r <= chksum_r + {24'h0, byte_data};
    end else begin
      chksum_r <= chksum_r;
    end
  end

  assign chksum = chksum_r;
`else
  assign chksum = 32'h0;
`endif

  assign byte_ready = byte_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign core_rst   = core_rst_r;
  assign itcm_addr  = itcm_addr_r;
  assign dtcm_addr  = dtcm_addr_r;

endmodule

// File: tb/tb_tcm_loader.sv
// tb_tcm_loader: scoreboard bench for tcm_loader. Expected ITCM/DTCM writes are
// queued when a load is driven and popped as the DUT issues them.
module tb_tcm_loader;

  logic        clk;
  logic        cpurst_n;
  logic        start;
  logic [14:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        itcm_we;
  logic [10:0] itcm_addr;
  logic [63:0] itcm_wdata;
  logic [3:0]  dtcm_we;
  logic [11:0] dtcm_addr;
  logic [31:0] dtcm_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic [31:0] chksum;

  typedef struct {
    int          addr;
    logic [3:0]  we;
    logic [63:0] data;
  } wr_t;

  wr_t  iq[$];
  wr_t  dq[$];
  wr_t  ie;
  wr_t  de;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   last_iaddr = -1;
  logic acc_prev = 1'b0;

  tcm_loader dut (
    .clk        (clk),
    .cpurst_n   (cpurst_n),
    .start      (start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .itcm_we    (itcm_we),
    .itcm_addr  (itcm_addr),
    .itcm_wdata (itcm_wdata),
    .dtcm_we    (dtcm_we),
    .dtcm_addr  (dtcm_addr),
    .dtcm_wdata (dtcm_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .chksum     (chksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int mode, input int i);
    logic [31:0] v;
    case (mode)
      0:       v = 32'(i);
      1:       v = 32'h11 + 32'(i);
      default: v = 32'hFF;
    endcase
    return v[7:0];
  endfunction

  // Record handshakes at the clock edge (pre-update values).
  always @(posedge clk) begin
    acc_prev <= byte_valid && byte_ready;
    if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
  end

  // Compare DUT writes against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (itcm_we) begin
      chk("itcm_we_after_acc", 64'(acc_prev), 64'd1);
      if (iq.size() == 0) begin
        chk("itcm_unexpected", 64'(itcm_addr), 64'hFFFF_FFFF);
      end else begin
        ie = iq.pop_front();
        chk("itcm_addr", 64'(itcm_addr), 64'(ie.addr));
        chk("itcm_wdata", itcm_wdata, ie.data);
        last_iaddr = int'(itcm_addr);
      end
    end
    if (dtcm_we != 4'h0) begin
      chk("dtcm_we_after_acc", 64'(acc_prev), 64'd1);
      if (dq.size() == 0) begin
        chk("dtcm_unexpected", 64'(dtcm_addr), 64'hFFFF_FFFF);
      end else begin
        de = dq.pop_front();
        chk("dtcm_addr", 64'(dtcm_addr), 64'(de.addr));
        chk("dtcm_we", 64'(dtcm_we), 64'(de.we));
        chk("dtcm_wdata", 64'(dtcm_wdata), de.data);
      end
    end
  end

  // Drive one load; abort>0 pulls reset after that many accepted bytes.
  task automatic run_load(input int len, input int mode, input int stall,
                          input bit inj_start, input int abort);
    int          eff;
    int          i;
    int          guard;
    int          acc0;
    logic [63:0] ibuf;
    logic [31:0] dbuf;
    logic [3:0]  dmask;
    logic [31:0] sum;
    logic [7:0]  b;
    bit          acc;
    wr_t         w;

    eff   = (len > 16384) ? 16384 : len;
    ibuf  = 64'h0;
    dbuf  = 32'h0;
    dmask = 4'h0;
    sum   = 32'h0;
    for (int k = 0; k < eff; k++) begin
      b = byte_of(mode, k);
      sum = sum + {24'h0, b};
      ibuf[8*(k%8) +: 8] = b;
      dbuf[8*(k%4) +: 8] = b;
      dmask[k%4] = 1'b1;
      if ((k % 8 == 7) || (k == eff - 1)) begin
        w.addr = k / 8; w.we = 4'h0; w.data = ibuf;
        iq.push_back(w);
        ibuf = 64'h0;
      end
      if ((k % 4 == 3) || (k == eff - 1)) begin
        w.addr = k / 4; w.we = dmask; w.data = {32'h0, dbuf};
        dq.push_back(w);
        dbuf = 32'h0;
        dmask = 4'h0;
      end
    end

    @(posedge clk); #1;
    start    = 1'b1;
    load_len = 15'(len);
    @(posedge clk); #1;
    start = 1'b0;
    acc0  = acc_cnt;
    chk("start_core_rst", 64'(core_rst), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);

    i = 0;
    guard = 0;
    while ((i < eff) && (guard < eff * 8 + 100) && !((abort > 0) && (i >= abort))) begin
      byte_valid = ($urandom_range(99) >= stall) ? 1'b1 : 1'b0;
      byte_data  = byte_of(mode, i);
      start      = (inj_start && (i == 10)) ? 1'b1 : 1'b0;
      acc        = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;

    if (abort > 0) begin
      cpurst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_core_rst", 64'(core_rst), 64'd1);
      chk("rst_ready", 64'(byte_ready), 64'd0);
      chk("rst_chksum", 64'(chksum), 64'd0);
      repeat (2) @(posedge clk);
      iq.delete();
      dq.delete();
      #1 cpurst_n = 1'b1;
      return;
    end

    chk("bytes_accepted", 64'(i), 64'(eff));
    // First cycle after the last accept is DRAIN.
    chk("drain_ready", 64'(byte_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("run_done", 64'(done), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_core_rst", 64'(core_rst), 64'd0);
    chk("accept_count", 64'(acc_cnt - acc0), 64'(eff));
`ifdef TCM_LOADER_CHKSUM_EN
    chk("chksum", 64'(chksum), 64'(sum));
`else
    chk("chksum", 64'(chksum), 64'd0);
`endif
    chk("itcm_queue_left", 64'(iq.size()), 64'd0);
    chk("dtcm_queue_left", 64'(dq.size()), 64'd0);

    // Stray bytes in RUN must be ignored.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    acc0 = acc_cnt;
    repeat (3) begin
      @(posedge clk); #1;
      chk("run_ready", 64'(byte_ready), 64'd0);
    end
    byte_valid = 1'b0;
    chk("run_stray", 64'(acc_cnt - acc0), 64'd0);
  endtask

  initial begin
    cpurst_n   = 1'b0;
    start      = 1'b0;
    load_len   = 15'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(byte_ready), 64'd0);
    chk("reset_core_rst", 64'(core_rst), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_itcm_we", 64'(itcm_we), 64'd0);
    chk("reset_dtcm_we", 64'(dtcm_we), 64'd0);
    chk("reset_itcm_addr", 64'(itcm_addr), 64'd0);
    chk("reset_chksum", 64'(chksum), 64'd0);
    cpurst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_core_rst", 64'(core_rst), 64'd1);

    run_load(16, 0, 0, 1'b0, 0);
    run_load(5, 1, 0, 1'b0, 0);
    run_load(20000, 0, 0, 1'b0, 0);
    chk("last_itcm_addr", 64'(last_iaddr), 64'd2047);
    run_load(64, 0, 40, 1'b1, 0);
    run_load(8, 1, 0, 1'b0, 3);
    run_load(8, 1, 0, 1'b0, 0);
    run_load(4, 2, 0, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcm_loader.md
TCM_LOADER -- requirements
Module: tcm_loader

Interface
REQ-001 SHALL have parameter ITCM_SIZE, default 16384, meaning TCM size in bytes (power of two, multiple of 8).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock.
- cpurst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- load_len  in  15  byte count to load.
- byte_valid  in  1  source byte valid.
- byte_data  in  8  source byte, little-endian order.
- byte_ready  out  1  loader accepts byte.
- itcm_we  out  1  ITCM 64-bit word write.
- itcm_addr  out  log2(ITCM_SIZE/8)  ITCM word index.
- itcm_wdata  out  64  ITCM word.
- dtcm_we  out  4  DTCM byte-lane enables.
- dtcm_addr  out  log2(ITCM_SIZE/4)  DTCM word index.
- dtcm_wdata  out  32  DTCM word.
- core_rst  out  1  active-high core reset hold.
- busy  out  1  load in progress.
- done  out  1  image loaded, core released.
- chksum  out  32  byte-sum of the loaded image.

Function
REQ-003 SHALL implement the FSM IDLE -> LOAD -> DRAIN -> RUN.
REQ-004 IDLE: byte_ready=0, core_rst=1; start with effective length 0 -> DRAIN; start with nonzero length -> LOAD; byte and word counters clear.
REQ-005 Effective length SHALL be min(load_len, ITCM_SIZE), sampled at start.
REQ-006 LOAD: byte_ready=1; a byte is accepted when byte_valid&byte_ready and placed in lane cnt[2:0] (ITCM) and cnt[1:0] (DTCM); cnt increments.
REQ-007 The accept completing an 8-byte group, or the last byte, SHALL produce itcm_we=1 for exactly one cycle, registered on the following cycle, with itcm_addr=cnt[..:3]; unfilled lanes are zero.
REQ-008 The accept completing a 4-byte group, or the last byte, SHALL produce dtcm_we on the following cycle with only the filled lanes set; dtcm_wdata lanes not enabled are zero.
REQ-009 Accepting the last byte SHALL move LOAD -> DRAIN; byte_ready SHALL be 0 in the cycle after that accept.
REQ-010 DRAIN SHALL last one cycle, during which the final registered writes are visible; it then moves to RUN.
REQ-011 RUN: core_rst=0, done=1, busy=0, byte_ready=0; stray byte_valid is ignored.
REQ-012 start in RUN SHALL re-enter LOAD; core_rst SHALL be 1 and done 0 in the next cycle.
REQ-013 start in LOAD or DRAIN SHALL be ignored.
REQ-014 busy SHALL be 1 in LOAD and DRAIN only.
REQ-015 Stalls (byte_valid=0) SHALL hold all state; no write is issued during a stall.

Reset
REQ-016 cpurst_n low SHALL asynchronously force:
- state IDLE;
- counters 0;
- core_rst=1;
- byte_ready, busy, done, itcm_we, dtcm_we and chksum all 0;
- addresses and wdata 0.
This applies mid-load; a partially assembled word is discarded.

Configuration
REQ-017 With TCM_LOADER_CHKSUM_EN defined, chksum SHALL accumulate a modulo-2^32 sum of accepted bytes, clearing at each start.
REQ-018 Without TCM_LOADER_CHKSUM_EN, chksum SHALL be constant 0 and no accumulator logic exists; the port remains.

Structure
REQ-019 Package tcm_loader_pkg SHALL hold the state enum, the default ITCM_SIZE and the address-width functions.
REQ-020 Sub-module tcm_word_pack SHALL perform byte-to-64-bit/32-bit lane assembly and lane-enable generation; tcm_loader instantiates it once.

Verification
REQ-021 The bench SHALL cover these scenarios:
- load_len=16, bytes 0x00..0x0F, no stalls -> ITCM[0]=0x0706050403020100, ITCM[1]=0x0F0E0D0C0B0A0908; DTCM words 0..3 with dtcm_we=4'hF; done=1 on the cycle after DRAIN.
- load_len=5, bytes 0x11..0x15 -> ITCM[0]=0x0000001514131211; DTCM[0]=0x14131211 with we=4'hF; DTCM[1]=0x00000015 with we=4'h1.
- load_len=20000 -> exactly 16384 bytes accepted; last itcm_addr=2047; byte_ready=0 afterward.
- Random byte_valid gaps during a 64-byte load -> memory contents identical to the no-stall case; no write issued in stall cycles.
- cpurst_n low after 3 bytes, then start with load_len=8 -> no write from the aborted load; ITCM[0] holds only the new image.
- TCM_LOADER_CHKSUM_EN defined, bytes 0xFF x 4 -> chksum=0x000003FC; undefined -> chksum=0.
